// File: rtl/task_pkg.sv
// Shared types and helpers for the task answer-side packer.
package task_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FLUSH   = 2'd1,
      SEND    = 2'd2
   } packer_state_t;

   localparam int ANSWER_WIDTH = 32;

   // Number of result words that fit in one answer word.
   function automatic int lanes_of(input int width);
      return ANSWER_WIDTH / width;
   endfunction

endpackage

// File: rtl/task_word_fifo.sv
// Single-clock first-word-fall-through buffer for packed answer words.
// The head word is always visible on o_rdata; o_count lets the packer
// recognise the final stored word of a packet.
module task_word_fifo #(
   parameter int DEPTH = 256,
   parameter int WIDTH = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_rd,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_wr, do_rd;

   // Pointer and occupancy update; writes when full and reads when empty are ignored.
   always_comb begin
      do_wr    = i_wr && (count_q != FULL_CNT);
      do_rd    = i_rd && (count_q != '0);
      wr_ptr_d = wr_ptr_q + AW'(do_wr);
      rd_ptr_d = rd_ptr_q + AW'(do_rd);
      count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
   end

   // Pointer registers.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge i_clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[rd_ptr_q];
   assign o_full  = (count_q == FULL_CNT);
   assign o_empty = (count_q == '0);
   assign o_count = count_q;

endmodule

// File: rtl/task_result_packer.sv
// Packs IN_WIDTH result words into 32-bit answer words, seals the packet
// when the last result arrives and streams it out under a ready handshake.
// Optional build macro: TASK_PACKER_LSB_FIRST_EN puts lane 0 in the LSBs
// (padding in the MSBs) instead of the default MSB-first packing.
//
// state   | meaning
// COLLECT | accepting result words, filling lanes, writing full words
// FLUSH   | one cycle: write the padded partial word, latch packet size
// SEND    | present buffer head to the manager until the final word leaves
module task_result_packer
   import task_pkg::*;
#(
   parameter int IN_WIDTH = 16,
   parameter int DEPTH    = 256,
   parameter int SIZE_W   = 12
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [IN_WIDTH-1:0] i_data,
   input  logic                i_data_valid,
   input  logic                i_data_last,
   output logic                o_in_ready,
   input  logic                i_manager_ready,
   output logic                o_answer_ready,
   output logic [31:0]         o_answer_data,
   output logic                o_answer_data_last,
   output logic [SIZE_W-1:0]   o_packet_size_in_bytes,
   output logic                o_overflow
);

   localparam int LANES  = lanes_of(IN_WIDTH);
   localparam int BPW    = IN_WIDTH / 8;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   generate
      if (!(IN_WIDTH == 8 || IN_WIDTH == 16 || IN_WIDTH == 32)) begin : g_bad_width
         $error("task_result_packer: IN_WIDTH must be 8, 16 or 32");
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("task_result_packer: DEPTH must be a power of two >= 2");
      end
      if (DEPTH * 4 > (2 ** SIZE_W) - 1) begin : g_bad_size
         $error("task_result_packer: SIZE_W too narrow for DEPTH*4 bytes");
      end
   endgenerate

   packer_state_t     state_q, state_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   logic [31:0]       pack_q, pack_d;
   logic [SIZE_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [SIZE_W-1:0] size_q, size_d;
   logic              ovf_q, ovf_d;
   logic              started_q, started_d;
   logic              in_ready_q, in_ready_d;
   logic              ans_ready_q, ans_ready_d;
   logic              last_q, last_d;

   logic              fifo_wr, fifo_rd, fifo_full, fifo_empty;
   logic [31:0]       fifo_wdata, fifo_rdata;
   logic [CNT_W-1:0]  fifo_count;
   logic [31:0]       ins_word;

   task_word_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_wr    (fifo_wr),
      .i_wdata (fifo_wdata),
      .i_rd    (fifo_rd),
      .o_rdata (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   // Current partial word with the incoming beat dropped into its lane.
   always_comb begin
      ins_word = pack_q;
      for (int l = 0; l < LANES; l++) begin
         if (lane_q == LANE_W'(l)) begin
`ifdef TASK_PACKER_LSB_FIRST_EN
            ins_word[l*IN_WIDTH +: IN_WIDTH] = i_data;
`else
            ins_word[(LANES-1-l)*IN_WIDTH +: IN_WIDTH] = i_data;
`endif
         end
      end
   end

   // Next-state logic: packing, byte counting, overflow and the handshake FSM.
   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      pack_d      = pack_q;
      byte_cnt_d  = byte_cnt_q;
      size_d      = size_q;
      ovf_d       = ovf_q;
      started_d   = started_q;
      in_ready_d  = in_ready_q;
      ans_ready_d = ans_ready_q;
      last_d      = last_q;
      fifo_wr     = 1'b0;
      fifo_wdata  = pack_q;
      fifo_rd     = 1'b0;

      case (state_q)
         COLLECT: begin
            if (i_data_valid && in_ready_q) begin
               started_d = 1'b1;
               if (fifo_full) begin
                  // Buffer exhausted: the beat is dropped and not counted.
                  ovf_d = 1'b1;
               end else begin
                  if (!started_q) begin
                     ovf_d = 1'b0;
                  end
                  byte_cnt_d = byte_cnt_q + SIZE_W'(BPW);
                  if (lane_q == LAST_LANE) begin
                     fifo_wr    = 1'b1;
                     fifo_wdata = ins_word;
                     pack_d     = '0;
                     lane_d     = '0;
                  end else begin
                     pack_d = ins_word;
                     lane_d = lane_q + LANE_W'(1);
                  end
               end
               if (i_data_last) begin
                  state_d    = FLUSH;
                  in_ready_d = 1'b0;
               end
            end
         end

         FLUSH: begin
            size_d = byte_cnt_q;
            if (lane_q != '0) begin
               fifo_wr    = 1'b1;
               fifo_wdata = pack_q;
               pack_d     = '0;
               lane_d     = '0;
            end
            // Occupancy after this cycle's write decides whether the head is final.
            last_d      = (((lane_q != '0) ? fifo_count + CNT_W'(1) : fifo_count)
                           == CNT_W'(1));
            ans_ready_d = 1'b1;
            state_d     = SEND;
         end

         SEND: begin
            if (ans_ready_q && i_manager_ready && !fifo_empty) begin
               fifo_rd = 1'b1;
               if (last_q) begin
                  state_d     = COLLECT;
                  ans_ready_d = 1'b0;
                  last_d      = 1'b0;
                  in_ready_d  = 1'b1;
                  byte_cnt_d  = '0;
                  started_d   = 1'b0;
                  lane_d      = '0;
                  pack_d      = '0;
               end else begin
                  last_d = (fifo_count == CNT_W'(2));
               end
            end
         end

         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q     <= COLLECT;
         lane_q      <= '0;
         pack_q      <= '0;
         byte_cnt_q  <= '0;
         size_q      <= '0;
         ovf_q       <= 1'b0;
         started_q   <= 1'b0;
         in_ready_q  <= 1'b1;
         ans_ready_q <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         pack_q      <= pack_d;
         byte_cnt_q  <= byte_cnt_d;
         size_q      <= size_d;
         ovf_q       <= ovf_d;
         started_q   <= started_d;
         in_ready_q  <= in_ready_d;
         ans_ready_q <= ans_ready_d;
         last_q      <= last_d;
      end
   end

   assign o_in_ready             = in_ready_q;
   assign o_answer_ready         = ans_ready_q;
   assign o_answer_data          = ans_ready_q ? fifo_rdata : 32'h0;
   assign o_answer_data_last     = last_q;
   assign o_packet_size_in_bytes = size_q;
   assign o_overflow             = ovf_q;

endmodule

// File: tb/tb_task_result_packer.sv
// Bench for task_result_packer: three instances (IN_WIDTH 16/8/32, DEPTH 4),
// table of directed packets, reset-in-SEND sequence and random packets
// checked against a byte/lane arithmetic model.
module tb_task_result_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data = '0;
   logic [2:0]  vld = '0;
   logic        last = 1'b0;
   logic        mgr = 1'b0;

   logic [2:0]  in_rdy, ans_rdy, ans_last, ovf;
   logic [31:0] ad [3];
   logic [11:0] sz [3];

   int total = 0;
   int bad = 0;

   logic [31:0] stim_q[$];
   logic [31:0] exp_q[$];
   int          exp_bytes;
   logic        exp_ovf;
   int          mgr_mode;

   always #5 clk = ~clk;

   task_result_packer #(.IN_WIDTH(16), .DEPTH(4), .SIZE_W(12)) u16 (
      .i_clk(clk), .i_rst(rst_n), .i_data(data[15:0]), .i_data_valid(vld[0]),
      .i_data_last(last), .o_in_ready(in_rdy[0]), .i_manager_ready(mgr),
      .o_answer_ready(ans_rdy[0]), .o_answer_data(ad[0]),
      .o_answer_data_last(ans_last[0]), .o_packet_size_in_bytes(sz[0]),
      .o_overflow(ovf[0]));

   task_result_packer #(.IN_WIDTH(8), .DEPTH(4), .SIZE_W(12)) u8 (
      .i_clk(clk), .i_rst(rst_n), .i_data(data[7:0]), .i_data_valid(vld[1]),
      .i_data_last(last), .o_in_ready(in_rdy[1]), .i_manager_ready(mgr),
      .o_answer_ready(ans_rdy[1]), .o_answer_data(ad[1]),
      .o_answer_data_last(ans_last[1]), .o_packet_size_in_bytes(sz[1]),
      .o_overflow(ovf[1]));

   task_result_packer #(.IN_WIDTH(32), .DEPTH(4), .SIZE_W(12)) u32 (
      .i_clk(clk), .i_rst(rst_n), .i_data(data), .i_data_valid(vld[2]),
      .i_data_last(last), .o_in_ready(in_rdy[2]), .i_manager_ready(mgr),
      .o_answer_ready(ans_rdy[2]), .o_answer_data(ad[2]),
      .o_answer_data_last(ans_last[2]), .o_packet_size_in_bytes(sz[2]),
      .o_overflow(ovf[2]));

   function automatic int width_of(input int d);
      return (d == 0) ? 16 : (d == 1) ? 8 : 32;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Reference: beats fill lanes in arrival order, capacity DEPTH words,
   // excess beats dropped; size counts stored beats only.
   function automatic void build_model(input int w, input int depth);
      int lanes, cap, n_st, wi, l, shift;
      lanes = 32 / w;
      cap   = depth * lanes;
      n_st  = (stim_q.size() < cap) ? stim_q.size() : cap;
      exp_q.delete();
      for (int i = 0; i < n_st; i++) begin
         wi = i / lanes;
         l  = i % lanes;
         if (wi >= exp_q.size()) exp_q.push_back(32'h0);
`ifdef TASK_PACKER_LSB_FIRST_EN
         shift = l * w;
`else
         shift = 32 - (l + 1) * w;
`endif
         exp_q[wi] = exp_q[wi] | (stim_q[i] << shift);
      end
      exp_bytes = n_st * w / 8;
      exp_ovf   = (stim_q.size() > cap);
   endfunction

   task automatic check_idle(input int d, input string nm);
      chk({nm, "_in_ready"}, {31'b0, in_rdy[d]}, 32'd1);
      chk({nm, "_ans_ready"}, {31'b0, ans_rdy[d]}, 32'd0);
      chk({nm, "_data"}, ad[d], 32'd0);
      chk({nm, "_last"}, {31'b0, ans_last[d]}, 32'd0);
   endtask

   task automatic run_packet(input int d, input string nm);
      int  cyc;
      int  got;
      bit  hold;
      bit  r;
      logic [31:0] prev_data;
      logic        prev_last;
      hold = 0;
      prev_data = '0;
      prev_last = 1'b0;
      mgr = 1'b0;
      for (int i = 0; i < stim_q.size(); i++) begin
         @(negedge clk);
         if (i == 0) chk({nm, "_in_ready_collect"}, {31'b0, in_rdy[d]}, 32'd1);
         data   = stim_q[i];
         vld[d] = 1'b1;
         last   = (i == stim_q.size() - 1);
      end
      @(negedge clk);
      vld  = '0;
      last = 1'b0;
      data = '0;
      chk({nm, "_flush_ans_ready"}, {31'b0, ans_rdy[d]}, 32'd0);
      chk({nm, "_flush_in_ready"}, {31'b0, in_rdy[d]}, 32'd0);
      chk({nm, "_overflow"}, {31'b0, ovf[d]}, {31'b0, exp_ovf});
      @(negedge clk);
      chk({nm, "_latency_ans_ready"}, {31'b0, ans_rdy[d]}, 32'd1);
      chk({nm, "_size"}, 32'(sz[d]), 32'(exp_bytes));
      got = 0;
      cyc = 0;
      while (got < exp_q.size() && cyc < 200) begin
         chk({nm, "_send_in_ready"}, {31'b0, in_rdy[d]}, 32'd0);
         chk({nm, "_send_ans_ready"}, {31'b0, ans_rdy[d]}, 32'd1);
         if (hold) begin
            chk({nm, "_stable_data"}, ad[d], prev_data);
            chk({nm, "_stable_last"}, {31'b0, ans_last[d]}, {31'b0, prev_last});
         end
         chk($sformatf("%s_word%0d", nm, got), ad[d], exp_q[got]);
         chk($sformatf("%s_last%0d", nm, got), {31'b0, ans_last[d]},
             {31'b0, (got == exp_q.size() - 1)});
         prev_data = ad[d];
         prev_last = ans_last[d];
         case (mgr_mode)
            0: r = 1'b1;
            1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: r = 1'($urandom_range(0, 1));
         endcase
         mgr  = r;
         hold = !r;
         if (r) got++;
         @(negedge clk);
         cyc++;
      end
      mgr = 1'b0;
      if (cyc >= 200) chk({nm, "_send_timeout"}, 32'd1, 32'd0);
      check_idle(d, {nm, "_after"});
      chk({nm, "_size_held"}, 32'(sz[d]), 32'(exp_bytes));
   endtask

   typedef struct {
      int          d;
      int          n;
      logic [31:0] beats [8];
      int          nw;
      logic [31:0] w [4];
      int          bytes;
      logic        ov;
      int          mode;
   } vec_t;

   vec_t vecs [5];

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int d, n, lanes;
      logic [31:0] mask;

      vecs[0].d = 0; vecs[0].n = 3;
      vecs[0].beats[0] = 32'h1111; vecs[0].beats[1] = 32'h2222; vecs[0].beats[2] = 32'h3333;
      vecs[0].nw = 2; vecs[0].bytes = 6; vecs[0].ov = 0; vecs[0].mode = 0;
`ifdef TASK_PACKER_LSB_FIRST_EN
      vecs[0].w[0] = 32'h22221111; vecs[0].w[1] = 32'h00003333;
`else
      vecs[0].w[0] = 32'h11112222; vecs[0].w[1] = 32'h33330000;
`endif
      vecs[1].d = 1; vecs[1].n = 5;
      for (int i = 0; i < 5; i++) vecs[1].beats[i] = 32'hA1 + 32'(i);
      vecs[1].nw = 2; vecs[1].bytes = 5; vecs[1].ov = 0; vecs[1].mode = 0;
`ifdef TASK_PACKER_LSB_FIRST_EN
      vecs[1].w[0] = 32'hA4A3A2A1; vecs[1].w[1] = 32'h000000A5;
`else
      vecs[1].w[0] = 32'hA1A2A3A4; vecs[1].w[1] = 32'hA5000000;
`endif
      vecs[2].d = 2; vecs[2].n = 6;
      for (int i = 0; i < 6; i++) vecs[2].beats[i] = 32'(i + 1);
      vecs[2].nw = 4;
      for (int i = 0; i < 4; i++) vecs[2].w[i] = 32'(i + 1);
      vecs[2].bytes = 16; vecs[2].ov = 1; vecs[2].mode = 0;
      vecs[3].d = 2; vecs[3].n = 1; vecs[3].beats[0] = 32'h77;
      vecs[3].nw = 1; vecs[3].w[0] = 32'h77; vecs[3].bytes = 4; vecs[3].ov = 0; vecs[3].mode = 0;
      vecs[4] = vecs[0];
      vecs[4].mode = 1;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_idle(i, $sformatf("reset%0d", i));
         chk($sformatf("reset%0d_size", i), 32'(sz[i]), 32'd0);
         chk($sformatf("reset%0d_ovf", i), {31'b0, ovf[i]}, 32'd0);
      end
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         stim_q.delete();
         exp_q.delete();
         for (int i = 0; i < vecs[v].n; i++) stim_q.push_back(vecs[v].beats[i]);
         for (int i = 0; i < vecs[v].nw; i++) exp_q.push_back(vecs[v].w[i]);
         exp_bytes = vecs[v].bytes;
         exp_ovf   = vecs[v].ov;
         mgr_mode  = vecs[v].mode;
         run_packet(vecs[v].d, $sformatf("vec%0d", v));
      end

      // Reset while SEND is presenting the first word of a 16-bit packet.
      stim_q = '{32'h1111, 32'h2222, 32'h3333};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         data = stim_q[i]; vld[0] = 1'b1; last = (i == 2);
      end
      @(negedge clk);
      vld = '0; last = 1'b0; data = '0;
      @(negedge clk);
      chk("rst_seq_in_send", {31'b0, ans_rdy[0]}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_idle(0, "rst_mid");
      chk("rst_mid_size", 32'(sz[0]), 32'd0);
      chk("rst_mid_ovf", {31'b0, ovf[0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stim_q = '{32'hBEEF, 32'hCAFE};
      build_model(16, 4);
      mgr_mode = 0;
      run_packet(0, "post_rst");

      // Random packets, including overflowing ones, with random backpressure.
      for (int it = 0; it < 30; it++) begin
         d     = int'($urandom_range(0, 2));
         lanes = 32 / width_of(d);
         n     = int'($urandom_range(1, 4 * lanes + 3));
         mask  = (width_of(d) == 32) ? 32'hFFFF_FFFF : ((32'h1 << width_of(d)) - 32'h1);
         stim_q.delete();
         for (int i = 0; i < n; i++) stim_q.push_back($urandom() & mask);
         build_model(width_of(d), 4);
         mgr_mode = 2;
         run_packet(d, $sformatf("rnd%0d", it));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
